// File: rtl/axi_slave_regbank.sv
// axi_slave_regbank
//   AXI slave holding a bank of 2**DEPTH_LOG2 32-bit registers. It sits in a
//   byte-addressed window that starts at BASE_ADDR. Bursts that start outside
//   the window are answered with SLVERR: writes are dropped and reads return 0.
//   The write path (AW/W/B) and the read path (AR/R) are independent state
//   machines that run concurrently.
//
// Ports
//   clk, rstn                       clock (rising edge), async active-low reset
//   SLAVE_WR_ADDR_*                 AW channel: ID, byte address, LEN, BURST, VALID/READY
//   SLAVE_WR_DATA_*                 W channel: data, byte strobes, LAST, VALID/READY
//   SLAVE_WR_BACK_*                 B channel: ID, RESP, VALID/READY
//   SLAVE_RD_ADDR_*                 AR channel: ID, byte address, LEN, BURST, VALID/READY
//   SLAVE_RD_BACK_ID, SLAVE_RD_DATA_* R channel: ID, data, RESP, LAST, VALID/READY
module axi_slave_regbank #(
  parameter int          S_ID       = 4,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic [S_ID-1:0] SLAVE_WR_ADDR_ID,
  input  logic [31:0]     SLAVE_WR_ADDR,
  input  logic [7:0]      SLAVE_WR_ADDR_LEN,
  input  logic [1:0]      SLAVE_WR_ADDR_BURST,
  input  logic            SLAVE_WR_ADDR_VALID,
  output logic            SLAVE_WR_ADDR_READY,

  input  logic [31:0]     SLAVE_WR_DATA,
  input  logic [3:0]      SLAVE_WR_DATA_STRB,
  input  logic            SLAVE_WR_DATA_LAST,
  input  logic            SLAVE_WR_DATA_VALID,
  output logic            SLAVE_WR_DATA_READY,

  output logic [S_ID-1:0] SLAVE_WR_BACK_ID,
  output logic [1:0]      SLAVE_WR_BACK_RESP,
  output logic            SLAVE_WR_BACK_VALID,
  input  logic            SLAVE_WR_BACK_READY,

  input  logic [S_ID-1:0] SLAVE_RD_ADDR_ID,
  input  logic [31:0]     SLAVE_RD_ADDR,
  input  logic [7:0]      SLAVE_RD_ADDR_LEN,
  input  logic [1:0]      SLAVE_RD_ADDR_BURST,
  input  logic            SLAVE_RD_ADDR_VALID,
  output logic            SLAVE_RD_ADDR_READY,

  output logic [S_ID-1:0] SLAVE_RD_BACK_ID,
  output logic [31:0]     SLAVE_RD_DATA,
  output logic [1:0]      SLAVE_RD_DATA_RESP,
  output logic            SLAVE_RD_DATA_LAST,
  output logic            SLAVE_RD_DATA_VALID,
  input  logic            SLAVE_RD_DATA_READY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] regs [DEPTH];

  // Only the word index and the window tag of each address are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{SLAVE_WR_ADDR[1:0], SLAVE_RD_ADDR[1:0]};

  function automatic logic in_window(input logic [31:0] addr);
    return addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2];
  endfunction

  // FIXED bursts revisit the same word; every other code walks forward and
  // wraps within the bank.
  function automatic logic [DEPTH_LOG2-1:0] next_addr(input logic [DEPTH_LOG2-1:0] addr,
                                                      input logic [1:0]            burst);
    return (burst == BURST_FIXED) ? addr : addr + ADDR_ONE;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_t              w_state, w_next;
  logic [S_ID-1:0]       w_id;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [7:0]            w_len;
  logic [1:0]            w_burst;
  logic                  w_inrange;
  logic [8:0]            w_cnt;
  logic [1:0]            w_resp;
  logic                  aw_ready, wd_ready, b_valid;
  logic                  aw_fire, w_fire, b_fire;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    wd_ready = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = rstn;
        if (SLAVE_WR_ADDR_VALID && rstn) w_next = W_DATA;
      end
      W_DATA: begin
        wd_ready = 1'b1;
        if (SLAVE_WR_DATA_VALID && SLAVE_WR_DATA_LAST) w_next = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (SLAVE_WR_BACK_READY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_fire = aw_ready & SLAVE_WR_ADDR_VALID;
  assign w_fire  = wd_ready & SLAVE_WR_DATA_VALID;
  assign b_fire  = b_valid  & SLAVE_WR_BACK_READY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_burst   <= '0;
      w_inrange <= 1'b0;
      w_cnt     <= '0;
      w_resp    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (aw_fire) begin
        w_id      <= SLAVE_WR_ADDR_ID;
        w_addr    <= SLAVE_WR_ADDR[DEPTH_LOG2+1:2];
        w_len     <= SLAVE_WR_ADDR_LEN;
        w_burst   <= SLAVE_WR_ADDR_BURST;
        w_inrange <= in_window(SLAVE_WR_ADDR);
        w_cnt     <= '0;
      end
      if (w_fire) begin
        if (w_inrange)
          regs[w_addr] <= merge_bytes(regs[w_addr], SLAVE_WR_DATA, SLAVE_WR_DATA_STRB);
        w_addr <= next_addr(w_addr, w_burst);
        // Saturate so an overlong burst can never wrap back onto LEN.
        if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
        // w_cnt is the zero-based index of this beat; OKAY needs LAST exactly on beat LEN.
        if (SLAVE_WR_DATA_LAST)
          w_resp <= (w_inrange && (w_cnt == {1'b0, w_len})) ? RESP_OKAY : RESP_SLVERR;
      end
      if (b_fire) w_resp <= w_resp;
    end
  end

  assign SLAVE_WR_ADDR_READY = aw_ready;
  assign SLAVE_WR_DATA_READY = wd_ready;
  assign SLAVE_WR_BACK_VALID = b_valid;
  assign SLAVE_WR_BACK_ID    = w_id;
  assign SLAVE_WR_BACK_RESP  = w_resp;

  // ----------------------------------------------------------------- read path
  r_state_t              r_state, r_next;
  logic [S_ID-1:0]       r_id;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [1:0]            r_burst;
  logic                  r_inrange;
  logic [1:0]            r_resp;
  logic [31:0]           r_data;
  logic                  ar_ready, r_valid, r_last;
  logic                  ar_fire, r_fire;
  logic                  ar_inrange;
  logic [DEPTH_LOG2-1:0] ar_word, r_addr_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  assign r_last = (r_beat == r_len);

  always_comb begin
    r_next   = r_state;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = rstn;
        if (SLAVE_RD_ADDR_VALID && rstn) r_next = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (SLAVE_RD_DATA_READY && r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_fire    = ar_ready & SLAVE_RD_ADDR_VALID;
  assign r_fire     = r_valid & SLAVE_RD_DATA_READY;
  assign ar_inrange = in_window(SLAVE_RD_ADDR);
  assign ar_word    = SLAVE_RD_ADDR[DEPTH_LOG2+1:2];
  assign r_addr_nxt = next_addr(r_addr, r_burst);

  // regs is read here with its pre-edge value, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_inrange <= 1'b0;
      r_resp    <= '0;
      r_data    <= '0;
    end else if (ar_fire) begin
      r_id      <= SLAVE_RD_ADDR_ID;
      r_addr    <= ar_word;
      r_len     <= SLAVE_RD_ADDR_LEN;
      r_beat    <= '0;
      r_burst   <= SLAVE_RD_ADDR_BURST;
      r_inrange <= ar_inrange;
      r_resp    <= ar_inrange ? RESP_OKAY : RESP_SLVERR;
      r_data    <= ar_inrange ? regs[ar_word] : '0;
    end else if (r_fire && !r_last) begin
      // Prefetch the next beat on the accepting edge so beats run back to back.
      r_addr <= r_addr_nxt;
      r_beat <= r_beat + 8'd1;
      r_data <= r_inrange ? regs[r_addr_nxt] : '0;
    end
  end

  assign SLAVE_RD_ADDR_READY = ar_ready;
  assign SLAVE_RD_DATA_VALID = r_valid;
  assign SLAVE_RD_DATA_LAST  = r_valid & r_last;
  assign SLAVE_RD_BACK_ID    = r_id;
  assign SLAVE_RD_DATA       = r_data;
  assign SLAVE_RD_DATA_RESP  = r_resp;

endmodule

// File: tb/tb_axi_slave_regbank.sv
module tb_axi_slave_regbank;

  localparam int S_ID = 4;
  localparam int NREG = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [S_ID-1:0] SLAVE_WR_ADDR_ID;
  logic [31:0]     SLAVE_WR_ADDR;
  logic [7:0]      SLAVE_WR_ADDR_LEN;
  logic [1:0]      SLAVE_WR_ADDR_BURST;
  logic            SLAVE_WR_ADDR_VALID;
  logic            SLAVE_WR_ADDR_READY;
  logic [31:0]     SLAVE_WR_DATA;
  logic [3:0]      SLAVE_WR_DATA_STRB;
  logic            SLAVE_WR_DATA_LAST;
  logic            SLAVE_WR_DATA_VALID;
  logic            SLAVE_WR_DATA_READY;
  logic [S_ID-1:0] SLAVE_WR_BACK_ID;
  logic [1:0]      SLAVE_WR_BACK_RESP;
  logic            SLAVE_WR_BACK_VALID;
  logic            SLAVE_WR_BACK_READY;
  logic [S_ID-1:0] SLAVE_RD_ADDR_ID;
  logic [31:0]     SLAVE_RD_ADDR;
  logic [7:0]      SLAVE_RD_ADDR_LEN;
  logic [1:0]      SLAVE_RD_ADDR_BURST;
  logic            SLAVE_RD_ADDR_VALID;
  logic            SLAVE_RD_ADDR_READY;
  logic [S_ID-1:0] SLAVE_RD_BACK_ID;
  logic [31:0]     SLAVE_RD_DATA;
  logic [1:0]      SLAVE_RD_DATA_RESP;
  logic            SLAVE_RD_DATA_LAST;
  logic            SLAVE_RD_DATA_VALID;
  logic            SLAVE_RD_DATA_READY;

  axi_slave_regbank #(.S_ID(S_ID), .DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn),
    .SLAVE_WR_ADDR_ID(SLAVE_WR_ADDR_ID), .SLAVE_WR_ADDR(SLAVE_WR_ADDR),
    .SLAVE_WR_ADDR_LEN(SLAVE_WR_ADDR_LEN), .SLAVE_WR_ADDR_BURST(SLAVE_WR_ADDR_BURST),
    .SLAVE_WR_ADDR_VALID(SLAVE_WR_ADDR_VALID), .SLAVE_WR_ADDR_READY(SLAVE_WR_ADDR_READY),
    .SLAVE_WR_DATA(SLAVE_WR_DATA), .SLAVE_WR_DATA_STRB(SLAVE_WR_DATA_STRB),
    .SLAVE_WR_DATA_LAST(SLAVE_WR_DATA_LAST), .SLAVE_WR_DATA_VALID(SLAVE_WR_DATA_VALID),
    .SLAVE_WR_DATA_READY(SLAVE_WR_DATA_READY),
    .SLAVE_WR_BACK_ID(SLAVE_WR_BACK_ID), .SLAVE_WR_BACK_RESP(SLAVE_WR_BACK_RESP),
    .SLAVE_WR_BACK_VALID(SLAVE_WR_BACK_VALID), .SLAVE_WR_BACK_READY(SLAVE_WR_BACK_READY),
    .SLAVE_RD_ADDR_ID(SLAVE_RD_ADDR_ID), .SLAVE_RD_ADDR(SLAVE_RD_ADDR),
    .SLAVE_RD_ADDR_LEN(SLAVE_RD_ADDR_LEN), .SLAVE_RD_ADDR_BURST(SLAVE_RD_ADDR_BURST),
    .SLAVE_RD_ADDR_VALID(SLAVE_RD_ADDR_VALID), .SLAVE_RD_ADDR_READY(SLAVE_RD_ADDR_READY),
    .SLAVE_RD_BACK_ID(SLAVE_RD_BACK_ID), .SLAVE_RD_DATA(SLAVE_RD_DATA),
    .SLAVE_RD_DATA_RESP(SLAVE_RD_DATA_RESP), .SLAVE_RD_DATA_LAST(SLAVE_RD_DATA_LAST),
    .SLAVE_RD_DATA_VALID(SLAVE_RD_DATA_VALID), .SLAVE_RD_DATA_READY(SLAVE_RD_DATA_READY)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain array of register words plus per-beat stimulus tables.
  logic [31:0] model [NREG];
  logic [31:0] wd [32];
  logic [3:0]  ws [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] addr);
    return (addr / 64) == 0;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int nbeats, input int bhold);
    int wa;
    int guard;
    bit inr;
    logic [1:0] eresp;
    inr = in_win(addr);
    wa  = (addr / 4) % NREG;
    SLAVE_WR_ADDR_ID = id; SLAVE_WR_ADDR = addr; SLAVE_WR_ADDR_LEN = len;
    SLAVE_WR_ADDR_BURST = burst; SLAVE_WR_ADDR_VALID = 1'b1;
    guard = 0;
    while (!SLAVE_WR_ADDR_READY && guard < 20) begin tick(); guard++; end
    check("aw_ready", SLAVE_WR_ADDR_READY, 1);
    tick();
    SLAVE_WR_ADDR_VALID = 1'b0;
    check("aw_ready_busy", SLAVE_WR_ADDR_READY, 0);
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      SLAVE_WR_DATA = wd[i]; SLAVE_WR_DATA_STRB = ws[i];
      SLAVE_WR_DATA_LAST = (i == nbeats - 1); SLAVE_WR_DATA_VALID = 1'b1;
      check("w_ready", SLAVE_WR_DATA_READY, 1);
      tick();
      SLAVE_WR_DATA_VALID = 1'b0;
      if (inr)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model[wa][8*b +: 8] = wd[i][8*b +: 8];
      if (burst != 2'b00) wa = (wa + 1) % NREG;
    end
    SLAVE_WR_DATA_LAST = 1'b0;
    eresp = (inr && nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
    check("b_valid", SLAVE_WR_BACK_VALID, 1);
    check("b_resp", SLAVE_WR_BACK_RESP, eresp);
    check("b_id", SLAVE_WR_BACK_ID, id);
    repeat (bhold) begin
      tick();
      check("b_hold_valid", SLAVE_WR_BACK_VALID, 1);
      check("b_hold_resp", SLAVE_WR_BACK_RESP, eresp);
    end
    SLAVE_WR_BACK_READY = 1'b1;
    tick();
    SLAVE_WR_BACK_READY = 1'b0;
    check("b_done", SLAVE_WR_BACK_VALID, 0);
    check("aw_ready_again", SLAVE_WR_ADDR_READY, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input int rhold);
    int wa;
    int guard;
    bit inr;
    logic [31:0] exp;
    inr = in_win(addr);
    wa  = (addr / 4) % NREG;
    SLAVE_RD_ADDR_ID = id; SLAVE_RD_ADDR = addr; SLAVE_RD_ADDR_LEN = len;
    SLAVE_RD_ADDR_BURST = burst; SLAVE_RD_ADDR_VALID = 1'b1;
    guard = 0;
    while (!SLAVE_RD_ADDR_READY && guard < 20) begin tick(); guard++; end
    check("ar_ready", SLAVE_RD_ADDR_READY, 1);
    tick();
    SLAVE_RD_ADDR_VALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      exp = inr ? model[wa] : 32'h0;
      check("r_valid", SLAVE_RD_DATA_VALID, 1);
      check("r_data", SLAVE_RD_DATA, exp);
      check("r_resp", SLAVE_RD_DATA_RESP, inr ? 2'b00 : 2'b10);
      check("r_last", SLAVE_RD_DATA_LAST, i == int'(len));
      check("r_id", SLAVE_RD_BACK_ID, id);
      if (i == 0)
        repeat (rhold) begin
          tick();
          check("r_hold_valid", SLAVE_RD_DATA_VALID, 1);
          check("r_hold_data", SLAVE_RD_DATA, exp);
        end
      SLAVE_RD_DATA_READY = 1'b1;
      tick();
      SLAVE_RD_DATA_READY = 1'b0;
      if (burst != 2'b00) wa = (wa + 1) % NREG;
    end
    check("r_done", SLAVE_RD_DATA_VALID, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  len;
    logic [31:0] addr;
    int          nb;

    rstn = 1'b0;
    SLAVE_WR_ADDR_ID = '0; SLAVE_WR_ADDR = '0; SLAVE_WR_ADDR_LEN = '0; SLAVE_WR_ADDR_BURST = '0;
    SLAVE_WR_ADDR_VALID = 1'b0; SLAVE_WR_DATA = '0; SLAVE_WR_DATA_STRB = '0;
    SLAVE_WR_DATA_LAST = 1'b0; SLAVE_WR_DATA_VALID = 1'b0; SLAVE_WR_BACK_READY = 1'b0;
    SLAVE_RD_ADDR_ID = '0; SLAVE_RD_ADDR = '0; SLAVE_RD_ADDR_LEN = '0; SLAVE_RD_ADDR_BURST = '0;
    SLAVE_RD_ADDR_VALID = 1'b0; SLAVE_RD_DATA_READY = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    check("rst_aw_ready", SLAVE_WR_ADDR_READY, 0);
    check("rst_ar_ready", SLAVE_RD_ADDR_READY, 0);
    check("rst_b_valid", SLAVE_WR_BACK_VALID, 0);
    check("rst_r_valid", SLAVE_RD_DATA_VALID, 0);
    check("rst_r_data", SLAVE_RD_DATA, 0);
    check("rst_r_last", SLAVE_RD_DATA_LAST, 0);
    check("rst_b_resp", SLAVE_WR_BACK_RESP, 0);
    rstn = 1'b1;
    #1;
    check("rel_aw_ready", SLAVE_WR_ADDR_READY, 1);
    check("rel_ar_ready", SLAVE_RD_ADDR_READY, 1);
    tick();

    // Single write/read at 0x8
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h8, 8'd0, 2'b01, 4'h5, 1, 0);
    do_read(32'h8, 8'd0, 2'b01, 4'h3, 0);
    check("reg2_direct", model[2], 32'hDEADBEEF);

    // INCR wrap from word 14
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(32'h38, 8'd3, 2'b01, 4'h6, 4, 0);
    do_read(32'h38, 8'd3, 2'b01, 4'h7, 0);

    // FIXED burst, partial strobe on the last beat
    wd[0] = 32'hAAAA_AAAA; wd[1] = 32'hBBBB_BBBB; wd[2] = 32'hCCCC_CCCC;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h1;
    do_write(32'h4, 8'd2, 2'b00, 4'h9, 3, 0);
    do_read(32'h4, 8'd0, 2'b01, 4'h1, 0);

    // Out-of-range write and read
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write(32'h100, 8'd0, 2'b01, 4'hA, 1, 0);
    do_read(32'h100, 8'd0, 2'b01, 4'hB, 0);
    do_read(32'h0, 8'd15, 2'b01, 4'hC, 0);

    // Early LAST with held-off B, overlong burst, held-off R
    for (int i = 0; i < 5; i++) begin wd[i] = 32'h5000_0000 + i; ws[i] = 4'hF; end
    do_write(32'h10, 8'd3, 2'b01, 4'h2, 3, 5);
    do_write(32'h20, 8'd1, 2'b01, 4'h4, 4, 0);
    do_read(32'h10, 8'd7, 2'b01, 4'hD, 5);

    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      len  = 8'($urandom_range(0, 4));
      addr = $urandom_range(0, 127);
      nb   = int'(len) + 1;
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      do_write(addr, len, 2'($urandom_range(0, 2)), 4'($urandom), nb, $urandom_range(0, 2));
      if (n % 2 == 0)
        do_read($urandom_range(0, 127), 8'($urandom_range(0, 5)), 2'($urandom_range(0, 2)),
                4'($urandom), $urandom_range(0, 2));
    end
    do_read(32'h0, 8'd15, 2'b01, 4'hE, 0);

    // Reset in the middle of a read burst
    SLAVE_RD_ADDR_ID = 4'h8; SLAVE_RD_ADDR = 32'h0; SLAVE_RD_ADDR_LEN = 8'd7;
    SLAVE_RD_ADDR_BURST = 2'b01; SLAVE_RD_ADDR_VALID = 1'b1;
    tick();
    SLAVE_RD_ADDR_VALID = 1'b0;
    check("mid_r_valid", SLAVE_RD_DATA_VALID, 1);
    check("mid_r_data", SLAVE_RD_DATA, model[0]);
    SLAVE_RD_DATA_READY = 1'b1;
    tick();
    SLAVE_RD_DATA_READY = 1'b0;
    rstn = 1'b0;
    #1;
    check("rst_mid_r_valid", SLAVE_RD_DATA_VALID, 0);
    check("rst_mid_r_data", SLAVE_RD_DATA, 0);
    check("rst_mid_ar_ready", SLAVE_RD_ADDR_READY, 0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    tick();
    rstn = 1'b1;
    #1;
    check("rel2_ar_ready", SLAVE_RD_ADDR_READY, 1);
    check("rel2_aw_ready", SLAVE_WR_ADDR_READY, 1);
    check("rel2_r_valid", SLAVE_RD_DATA_VALID, 0);
    tick();
    do_read(32'h0, 8'd15, 2'b01, 4'h2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_slave_regbank.md
AXI_SLAVE_REGBANK -- requirements
Module: axi_slave_regbank

Interface
REQ-001 SHALL have parameter S_ID, default 4, meaning width of the AXI ID carried on the slave side of the switch.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the number of 32-bit registers (default 16).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the base byte address of the register window.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL provide the ports below, one per line as name, direction, width, meaning:
  clk  in  1  clock, all state on rising edge.
  rstn  in  1  async active-low reset.
  SLAVE_WR_ADDR_ID / SLAVE_WR_ADDR / _LEN / _BURST / _VALID  in  S_ID/32/8/2/1  AW channel.
  SLAVE_WR_ADDR_READY  out  1  AW ready.
  SLAVE_WR_DATA / _STRB / _LAST / _VALID  in  32/4/1/1  W channel.
  SLAVE_WR_DATA_READY  out  1  W ready.
  SLAVE_WR_BACK_ID / _RESP / _VALID  out  S_ID/2/1  B channel.
  SLAVE_WR_BACK_READY  in  1  B ready.
  SLAVE_RD_ADDR_ID / SLAVE_RD_ADDR / _LEN / _BURST / _VALID  in  S_ID/32/8/2/1  AR channel.
  SLAVE_RD_ADDR_READY  out  1  AR ready.
  SLAVE_RD_BACK_ID / SLAVE_RD_DATA / _RESP / _LAST / _VALID  out  S_ID/32/2/1/1  R channel.
  SLAVE_RD_DATA_READY  in  1  R ready.

Function
REQ-006 Handshake SHALL occur on a rising edge with VALID=1 and READY=1; once asserted, out VALID and payload SHALL hold until accepted.
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; WR_ADDR_READY=1 only in W_IDLE, WR_DATA_READY=1 only in W_DATA, WR_BACK_VALID=1 only in W_RESP.
REQ-008 AW handshake SHALL latch ID, word address ADDR[DEPTH_LOG2+1:2], LEN, BURST, in-range flag, clear the beat counter, and go to W_DATA.
REQ-009 In-range SHALL mean ADDR[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]; ADDR[1:0] ignored.
REQ-010 Each W beat SHALL update byte lanes with STRB=1 of the current word, only if in-range; STRB=0 lanes unchanged.
REQ-011 After each beat, word address SHALL stay for BURST=2'b00 (FIXED) and increment modulo 2**DEPTH_LOG2 for all other codes; beat counter (9 bit) increments.
REQ-012 Beat with WR_DATA_LAST=1 SHALL move W_DATA->W_RESP; beats after LEN+1 without LAST SHALL still be written (address advancing) until LAST.
REQ-013 WR_BACK_RESP SHALL be 2'b00 when in-range and LAST arrived on beat LEN+1 exactly, else 2'b10 (SLVERR); WR_BACK_ID = latched ID.
REQ-014 B handshake SHALL return write FSM to W_IDLE; next AW accepted no earlier than the following cycle.
REQ-015 Read FSM SHALL have states R_IDLE, R_DATA; RD_ADDR_READY=1 only in R_IDLE; RD_DATA_VALID=1 only in R_DATA.
REQ-016 AR handshake SHALL latch ID/LEN/BURST/range, and on the same edge register beat 0 data, so RD_DATA_VALID rises the cycle after AR handshake (latency 1).
REQ-017 Each R beat SHALL present RD_DATA = register (0 if out-of-range), RD_DATA_RESP 2'b00 in-range else 2'b10, RD_BACK_ID = latched ID, RD_DATA_LAST=1 iff beat index == LEN.
REQ-018 R handshake on a non-last beat SHALL advance address per REQ-011 and register next beat data on that edge (no bubble); on last beat return to R_IDLE.
REQ-019 Read data SHALL be sampled from register contents before any write on the same edge (old value on same-cycle collision).
REQ-020 Read and write FSMs SHALL operate fully concurrently and independently.

Reset
REQ-021 On rstn=0, immediately: FSMs to W_IDLE/R_IDLE; all VALID, READY, LAST, RESP, ID, DATA outputs 0; all registers 0; counters 0.
REQ-022 Reset mid-burst SHALL abandon the burst without a B or further R beat; registers already written are cleared.
REQ-023 After rstn deasserts, WR_ADDR_READY and RD_ADDR_READY SHALL be 1 on the first clock edge.

Verification
REQ-024 Single write ADDR=0x8, LEN=0, DATA=0xDEADBEEF, STRB=4'hF -> B RESP=00, ID echoed; read ADDR=0x8 -> DATA 0xDEADBEEF, LAST=1, one cycle after AR.
REQ-025 INCR write ADDR=0x38, LEN=3, data 1..4 -> regs 14,15,0,1 = 1,2,3,4 (wrap); INCR read same -> 1,2,3,4, LAST on 4th beat.
REQ-026 FIXED write ADDR=0x4, LEN=2, data A,B,C with STRB 4'h1 on C -> reg1 = {B[31:8],C[7:0]}.
REQ-027 Write ADDR=BASE+0x100 (out-of-range) -> B RESP=10, no register changes; read there -> DATA 0, RESP 10.
REQ-028 LAST on beat 2 with LEN=3 -> RESP=10; R/B READY held low 5 cycles -> outputs stable; rstn pulse mid-read -> VALID 0 immediately, ADDR_READY 1 after release.
